mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multicycle main control unit for the MIPS datapath: a Moore state machine that decodes the opcode held in IR[31:26] and drives every datapath control strobe (PC/IR/memory/register-file write enables, mux selects, ALUOp) one state per clock. It sits directly upstream of the datapath top, replacing the opcode-only `control` instance. It also exposes the current state, an illegal-opcode halt flag and a retired-instruction counter for debug.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26] from datapath
- PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA  out  1 each  datapath strobes/selects
- ALUSrcB, ALUOp, PCSource  out  2 each  datapath mux selects / ALU class
- state  out  4  current state encoding
- illegal  out  1  high while halted on unsupported opcode
- instr_count  out  CNT_W  instructions retired since reset

## Operation
- Mux encodings as wired in datapath: ALUSrcA 0=reg A, 1=PC; ALUSrcB 00=B, 01=4, 10=sign-ext imm, 11=imm<<2; PCSource 00=ALU result, 01=ALUout, 10=jump addr; ALUOp 00=add, 01=sub, 10=funct.
- Outputs are pure decode of the state register (no opcode path to outputs). Unlisted outputs are 0.
- States (encoding):
  - IDLE 15: all outputs 0; -> FETCH.
  - FETCH 0: MemRead, IRWrite, PCWrite, ALUSrcA=1, ALUSrcB=01, ALUOp=00, PCSource=00, IorD=0; -> DECODE.
  - DECODE 1: ALUSrcA=1, ALUSrcB=11, ALUOp=00; branch on opcode: 100011/101011 -> MEMADDR, 000000 -> EXEC, 000100 -> BRANCH, 000010 -> JUMP, 001000 -> ADDI_EX (macro only), else -> TRAP.
  - MEMADDR 2: ALUSrcA=0, ALUSrcB=10, ALUOp=00; lw -> MEMRD, sw -> MEMWR (opcode resampled; IR stable).
  - MEMRD 3: MemRead, IorD=1; -> MEMWB.
  - MEMWB 4: RegWrite, MemtoReg=1, RegDst=0; -> FETCH.
  - MEMWR 5: MemWrite, IorD=1; -> FETCH.
  - EXEC 6: ALUSrcA=0, ALUSrcB=00, ALUOp=10; -> RWB.
  - RWB 7: RegWrite, RegDst=1, MemtoReg=0; -> FETCH.
  - BRANCH 8: ALUSrcA=0, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01; -> FETCH.
  - JUMP 9: PCWrite, PCSource=10; -> FETCH.
  - ADDI_EX 10: ALUSrcA=0, ALUSrcB=10, ALUOp=00; -> ADDI_WB.
  - ADDI_WB 11: RegWrite, RegDst=0, MemtoReg=0; -> FETCH.
  - TRAP 12: all strobes 0, illegal=1; stays until reset.
- Unused encodings (13, 14) -> TRAP.
- instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDI_WB; wraps modulo 2^CNT_W. IDLE->FETCH does not count.

## Timing
- Reset (async): state=IDLE, instr_count=0; all control outputs 0, illegal=0, state output 15, immediately on reset assertion.
- First FETCH is the second rising edge after reset deasserts (IDLE occupies one cycle).
- Cycles per instruction, FETCH to next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- instr_count visible updated in the FETCH cycle following retirement.
- Reset mid-instruction: aborts immediately to IDLE; no partial strobe survives the reset edge.
- Only one of PCWrite/PCWriteCond, and one of MemRead/MemWrite, high in any state.

## Configuration
- ADDI_EN: defined -> opcode 001000 decodes to ADDI_EX/ADDI_WB. Undefined -> 001000 goes to TRAP; states 10/11 unreachable and treated as illegal encodings (-> TRAP).

## Test plan
- Reset held 3 cycles then released -> all outputs 0, state=15 during reset; state=0 with MemRead=IRWrite=PCWrite=1 two edges after release.
- opcode=100011 -> state sequence 0,1,2,3,4,0; RegWrite=MemtoReg=1 only in state 4; instr_count 0->1.
- opcode=101011 then 000000 -> 0,1,2,5,0 then 0,1,6,7,0; MemWrite only in 5, RegDst=1 only in 7; instr_count=2.
- opcode=000100 then 000010 -> 0,1,8,0 (PCWriteCond=1, PCSource=01) then 0,1,9,0 (PCWrite=1, PCSource=10).
- opcode=001000: with ADDI_EN -> 0,1,10,11,0, ALUSrcB=10 in 10; without -> 0,1,12, illegal=1 held 10 cycles until reset.
- CNT_W=4, 16 R-type instructions -> instr_count wraps 15->0; reset asserted in state 3 -> state=15 and MemRead=0 same cycle.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control: Moore FSM decoding IR[31:26] into datapath strobes.
// Optional macro ADDI_EN adds the addi execute/write-back states (10/11).
module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  output logic             PCWriteCond,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADDR = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RWB     = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDI_EX = 4'd10,
    ADDI_WB = 4'd11,
    TRAP    = 4'd12,
    IDLE    = 4'd15
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTY  = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t           state_q, state_d;
  logic             started_q;
  logic             retire;
  logic [CNT_W-1:0] count_q;

  // started_q holds IDLE for one full cycle after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      started_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    illegal     = 1'b0;
    case (state_q)
      IDLE: if (started_q) state_d = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b01;
        state_d = DECODE;
      end
      DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADDR;
          OP_RTY:       state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
`ifdef ADDI_EN
          OP_ADDI:      state_d = ADDI_EX;
`endif
          default:      state_d = TRAP;
        endcase
      end
      MEMADDR: begin
        ALUSrcB = 2'b10;
        if (opcode == OP_LW)      state_d = MEMRD;
        else if (opcode == OP_SW) state_d = MEMWR;
        else                      state_d = TRAP;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      EXEC: begin
        ALUOp   = 2'b10;
        state_d = RWB;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        retire      = 1'b1;
        state_d     = FETCH;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        retire   = 1'b1;
        state_d  = FETCH;
      end
`ifdef ADDI_EN
      ADDI_EX: begin
        ALUSrcB = 2'b10;
        state_d = ADDI_WB;
      end
      ADDI_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
`endif
      TRAP: illegal = 1'b1;
      default: state_d = TRAP;
    endcase
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm (CNT_W=4 so the retire counter wrap is reachable).
module tb_mc_control_fsm;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode;
  logic             PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg;
  logic             IRWrite, RegDst, RegWrite, ALUSrcA, illegal;
  logic [1:0]       ALUSrcB, ALUOp, PCSource;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  int checks = 0;
  int errors = 0;

  mc_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .illegal(illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All control strobes packed for zero checks.
  function automatic logic [31:0] ctl_all();
    return {14'd0, PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg,
            IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
  endfunction

  initial begin
    int exp_cnt;
    reset  = 1'b1;
    opcode = 6'b000000;
    #1;
    chk("rst_state", state, 15);
    chk("rst_ctl", ctl_all(), 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_cnt", instr_count, 0);
    tick(); tick(); tick();
    chk("rst_hold_state", state, 15);
    reset = 1'b0;
    tick();
    chk("idle_cycle", state, 15);
    chk("idle_ctl", ctl_all(), 0);
    tick();
    chk("fetch_state", state, 0);
    chk("fetch_rd_ir_pc", {MemRead, IRWrite, PCWrite}, 3'b111);
    chk("fetch_src", {ALUSrcA, ALUSrcB, ALUOp, PCSource, IorD}, 8'b1_01_00_00_0);

    // lw
    opcode = 6'b100011;
    tick(); chk("lw_s1", state, 1); chk("dec_srcb", ALUSrcB, 2'b11); chk("dec_srca", ALUSrcA, 1);
    tick(); chk("lw_s2", state, 2); chk("maddr_src", {ALUSrcA, ALUSrcB}, 3'b0_10);
    tick(); chk("lw_s3", state, 3); chk("memrd", {MemRead, IorD, RegWrite}, 3'b110);
    tick(); chk("lw_s4", state, 4); chk("memwb", {RegWrite, MemtoReg, RegDst}, 3'b110);
    tick(); chk("lw_fetch", state, 0); chk("lw_cnt", instr_count, 1);

    // sw
    opcode = 6'b101011;
    tick(); chk("sw_s1", state, 1);
    tick(); chk("sw_s2", state, 2);
    tick(); chk("sw_s5", state, 5); chk("memwr", {MemWrite, MemRead, IorD, RegWrite}, 4'b1010);
    tick(); chk("sw_fetch", state, 0); chk("sw_cnt", instr_count, 2);

    // R-type
    opcode = 6'b000000;
    tick(); chk("r_s1", state, 1);
    tick(); chk("r_s6", state, 6); chk("exec_aluop", {ALUSrcA, ALUSrcB, ALUOp}, 5'b0_00_10);
    tick(); chk("r_s7", state, 7); chk("rwb", {RegWrite, RegDst, MemtoReg}, 3'b110);
    tick(); chk("r_fetch", state, 0); chk("r_cnt", instr_count, 3);

    // beq
    opcode = 6'b000100;
    tick(); chk("beq_s1", state, 1);
    tick(); chk("beq_s8", state, 8);
    chk("branch", {PCWriteCond, PCWrite, PCSource, ALUOp}, 6'b10_01_01);
    tick(); chk("beq_fetch", state, 0); chk("beq_cnt", instr_count, 4);

    // j
    opcode = 6'b000010;
    tick(); chk("j_s1", state, 1);
    tick(); chk("j_s9", state, 9);
    chk("jump", {PCWrite, PCWriteCond, PCSource}, 4'b10_10);
    tick(); chk("j_fetch", state, 0); chk("j_cnt", instr_count, 5);

    // R-types until the 4-bit counter wraps 15 -> 0
    opcode  = 6'b000000;
    exp_cnt = 5;
    for (int i = 0; i < 11; i++) begin
      tick(); tick(); tick(); tick();
      exp_cnt = (exp_cnt + 1) % 16;
      chk("wrap_fetch", state, 0);
      chk("wrap_cnt", instr_count, exp_cnt);
    end
    chk("wrap_zero", instr_count, 0);

    // Reset asserted mid-lw in MEMRD
    opcode = 6'b100011;
    tick(); tick(); tick();
    chk("mid_s3", state, 3);
    chk("mid_memrd", MemRead, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_state", state, 15);
    chk("mid_rst_memrd", MemRead, 0);
    chk("mid_rst_ctl", ctl_all(), 0);
    tick();
    reset = 1'b0;
    tick(); chk("rel_idle", state, 15);
    tick(); chk("rel_fetch", state, 0);

    // addi
    opcode = 6'b001000;
    tick(); chk("addi_s1", state, 1);
    tick();
`ifdef ADDI_EN
    chk("addi_s10", state, 10); chk("addi_ex_src", {ALUSrcA, ALUSrcB, ALUOp}, 5'b0_10_00);
    tick(); chk("addi_s11", state, 11); chk("addi_wb", {RegWrite, RegDst, MemtoReg}, 3'b100);
    tick(); chk("addi_fetch", state, 0); chk("addi_cnt", instr_count, 1);
    opcode = 6'b111111;
    tick(); chk("bad_s1", state, 1);
    tick();
`endif
    chk("trap_state", state, 12);
    chk("trap_illegal", illegal, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("trap_hold_state", state, 12);
      chk("trap_hold_illegal", illegal, 1);
      chk("trap_hold_ctl", ctl_all(), 0);
    end
    #2 reset = 1'b1;
    #1;
    chk("trap_rst_state", state, 15);
    chk("trap_rst_illegal", illegal, 0);
    chk("trap_rst_cnt", instr_count, 0);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("final_fetch", state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
